// File: rtl/ysyx_23060201_mem_arb_if.sv
// Bus bundle for the IFU/LSU-to-memory arbiter: two requester channels plus the shared memory port.
// slave is the arbiter's view; master is the surrounding system (requesters and memory model).
interface ysyx_23060201_mem_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_WIDTH-1:0] ifu_addr;
  logic                  ifu_resp_valid;
  logic [DATA_WIDTH-1:0] ifu_rdata;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic                  lsu_wen;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic [DATA_WIDTH-1:0] lsu_wdata;
  logic [7:0]            lsu_wmask;
  logic                  lsu_resp_valid;
  logic [DATA_WIDTH-1:0] lsu_rdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [7:0]            mem_wmask;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  err_timeout;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output err_timeout
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  err_timeout
  );
endinterface

// File: rtl/ysyx_23060201_mem_arb.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU, with sticky response timeout.
// Define YSYX_23060201_MEM_ARB_RR_EN for round-robin; default build gives LSU fixed priority.
module ysyx_23060201_mem_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic clk,
  input logic rst,
  ysyx_23060201_mem_arb_if.slave bus
);
  // state | meaning
  // IDLE  | no transaction; grant a requester this cycle
  // REQ   | mem_req_valid held until memory accepts
  // WAIT  | counting cycles until mem_resp_valid or timeout
  // RESP  | one-cycle resp_valid to the owner
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t                state;
  logic                  owner_lsu;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [7:0]            wmask_q;
  logic [CW-1:0]         cnt;
  logic                  err_q;
  logic                  mem_valid_q;
  logic                  ifu_resp_q;
  logic                  lsu_resp_q;
  logic                  grant_lsu;
  logic                  grant_ifu;

`ifdef YSYX_23060201_MEM_ARB_RR_EN
  logic last_lsu;
  assign grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_lsu);
`else
  assign grant_lsu = bus.lsu_req_valid;
`endif
  assign grant_ifu = bus.ifu_req_valid && !grant_lsu;

  // Ready must be combinational so the handshake completes in the grant cycle itself.
  assign bus.lsu_req_ready  = (state == IDLE) && grant_lsu;
  assign bus.ifu_req_ready  = (state == IDLE) && grant_ifu;
  assign bus.mem_req_valid  = mem_valid_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
  assign bus.ifu_resp_valid = ifu_resp_q;
  assign bus.lsu_resp_valid = lsu_resp_q;
  assign bus.ifu_rdata      = data_q;
  assign bus.lsu_rdata      = data_q;
  assign bus.err_timeout    = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_lsu   <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      data_q      <= '0;
      cnt         <= '0;
      err_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
`ifdef YSYX_23060201_MEM_ARB_RR_EN
      last_lsu    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_lsu || grant_ifu) begin
            state       <= REQ;
            mem_valid_q <= 1'b1;
            owner_lsu   <= grant_lsu;
            if (grant_lsu) begin
              addr_q  <= bus.lsu_addr;
              wdata_q <= bus.lsu_wdata;
              wmask_q <= bus.lsu_wmask;
              wen_q   <= bus.lsu_wen;
            end else begin
              addr_q  <= bus.ifu_addr;
              wdata_q <= '0;
              wmask_q <= '0;
              wen_q   <= 1'b0;
            end
`ifdef YSYX_23060201_MEM_ARB_RR_EN
            last_lsu <= grant_lsu;
`endif
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            state       <= WAIT;
            mem_valid_q <= 1'b0;
            cnt         <= '0;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            state      <= RESP;
            data_q     <= wen_q ? '0 : bus.mem_rdata;
            ifu_resp_q <= !owner_lsu;
            lsu_resp_q <= owner_lsu;
          end else if (cnt == TO_LAST) begin
            // Final WAIT cycle: counter lands on TIMEOUT and stops there.
            state      <= RESP;
            cnt        <= cnt + 1'b1;
            err_q      <= 1'b1;
            data_q     <= '0;
            ifu_resp_q <= !owner_lsu;
            lsu_resp_q <= owner_lsu;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          ifu_resp_q <= 1'b0;
          lsu_resp_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060201_mem_arb.sv
// Directed bench for ysyx_23060201_mem_arb: vector table of full transactions plus timeout and reset sequences.
// Expected grant order follows YSYX_23060201_MEM_ARB_RR_EN when defined.
module tb_ysyx_23060201_mem_arb;
  logic clk = 1'b0;
  logic rst;

  ysyx_23060201_mem_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ysyx_23060201_mem_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        lv;
    logic        wen;
    logic [31:0] iaddr;
    logic [31:0] laddr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    int          delay;
    logic [31:0] mrdata;
    logic        exp_lsu;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [7:0]  exp_wmask;
    logic [31:0] exp_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic lv, input logic wen,
                              input logic [31:0] iaddr, input logic [31:0] laddr,
                              input logic [31:0] wdata, input logic [7:0] wmask,
                              input int delay, input logic [31:0] mrdata,
                              input logic exp_lsu, input logic [31:0] exp_addr,
                              input logic exp_wen, input logic [7:0] exp_wmask,
                              input logic [31:0] exp_rdata);
    vec_t v;
    v.iv = iv; v.lv = lv; v.wen = wen; v.iaddr = iaddr; v.laddr = laddr;
    v.wdata = wdata; v.wmask = wmask; v.delay = delay; v.mrdata = mrdata;
    v.exp_lsu = exp_lsu; v.exp_addr = exp_addr; v.exp_wen = exp_wen;
    v.exp_wmask = exp_wmask; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // Starts in IDLE (#1 after an edge); ends in the IDLE cycle after RESP.
  task automatic run_vec(input vec_t v, input string tag);
    bus.ifu_req_valid  = v.iv;
    bus.ifu_addr       = v.iaddr;
    bus.lsu_req_valid  = v.lv;
    bus.lsu_wen        = v.wen;
    bus.lsu_addr       = v.laddr;
    bus.lsu_wdata      = v.wdata;
    bus.lsu_wmask      = v.wmask;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    #2;
    chk({tag, ".lsu_ready"}, bus.lsu_req_ready, v.exp_lsu);
    chk({tag, ".ifu_ready"}, bus.ifu_req_ready, !v.exp_lsu);
    @(posedge clk); #1;
    bus.ifu_addr  = ~v.iaddr;
    bus.lsu_addr  = ~v.laddr;
    bus.lsu_wdata = ~v.wdata;
    bus.lsu_wmask = ~v.wmask;
    bus.lsu_wen   = ~v.wen;
    for (int i = 0; i <= v.delay; i++) begin
      bus.mem_req_ready = (i == v.delay);
      #2;
      chk({tag, ".mem_valid"}, bus.mem_req_valid, 1'b1);
      chk({tag, ".mem_addr"}, bus.mem_addr, v.exp_addr);
      chk({tag, ".mem_wen"}, bus.mem_wen, v.exp_wen);
      chk({tag, ".mem_wmask"}, bus.mem_wmask, v.exp_wmask);
      if (v.exp_lsu) chk({tag, ".mem_wdata"}, bus.mem_wdata, v.wdata);
      chk({tag, ".ready_req"}, {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
      @(posedge clk); #1;
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = v.mrdata;
    #2;
    chk({tag, ".wait_valid"}, bus.mem_req_valid, 1'b0);
    chk({tag, ".wait_resp"}, {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h5a5a_a5a5;
    #2;
    chk({tag, ".ifu_resp"}, bus.ifu_resp_valid, !v.exp_lsu);
    chk({tag, ".lsu_resp"}, bus.lsu_resp_valid, v.exp_lsu);
    chk({tag, ".rdata"}, v.exp_lsu ? bus.lsu_rdata : bus.ifu_rdata, v.exp_rdata);
    chk({tag, ".ready_resp"}, {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
    @(posedge clk); #1;
    chk({tag, ".resp_end"}, {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
  endtask

  task automatic idle_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ready"}, {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
    chk({tag, ".resp"}, {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
    chk({tag, ".mem_valid"}, bus.mem_req_valid, 1'b0);
    chk({tag, ".mem_wen"}, bus.mem_wen, 1'b0);
    chk({tag, ".mem_wmask"}, bus.mem_wmask, 8'h00);
    chk({tag, ".mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, 32'h0);
    chk({tag, ".rdata"}, {bus.ifu_rdata, bus.lsu_rdata}, 64'h0);
    chk({tag, ".err"}, bus.err_timeout, 1'b0);
  endtask

  vec_t vecs[8];

  initial begin
    int  n;
    logic err_early;

    vecs[0] = mk(1, 0, 0, 32'h8000_0000, 32'h0, 32'h0, 8'h00, 0, 32'h0000_0413,
                 0, 32'h8000_0000, 0, 8'h00, 32'h0000_0413);
    vecs[1] = mk(0, 1, 1, 32'h0, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 4, 32'h1234_5678,
                 1, 32'h8000_1000, 1, 8'h0F, 32'h0);
    vecs[2] = mk(0, 1, 0, 32'h0, 32'h8000_2004, 32'h0, 8'h00, 1, 32'hCAFE_F00D,
                 1, 32'h8000_2004, 0, 8'h00, 32'hCAFE_F00D);
`ifdef YSYX_23060201_MEM_ARB_RR_EN
    vecs[3] = mk(1, 1, 1, 32'h8000_0100, 32'h8000_2100, 32'h0BAD_F00D, 8'hFF, 0, 32'h1111_2222,
                 0, 32'h8000_0100, 0, 8'h00, 32'h1111_2222);
    vecs[4] = mk(1, 1, 0, 32'h8000_0004, 32'h8000_3000, 32'h0, 8'h00, 0, 32'hA000_0001,
                 1, 32'h8000_3000, 0, 8'h00, 32'hA000_0001);
    vecs[5] = mk(1, 1, 0, 32'h8000_0008, 32'h8000_3004, 32'h0, 8'h00, 0, 32'hA000_0002,
                 0, 32'h8000_0008, 0, 8'h00, 32'hA000_0002);
    vecs[6] = mk(1, 1, 0, 32'h8000_000C, 32'h8000_3008, 32'h0, 8'h00, 0, 32'hA000_0003,
                 1, 32'h8000_3008, 0, 8'h00, 32'hA000_0003);
    vecs[7] = mk(1, 1, 0, 32'h8000_0010, 32'h8000_300C, 32'h0, 8'h00, 0, 32'hA000_0004,
                 0, 32'h8000_0010, 0, 8'h00, 32'hA000_0004);
`else
    vecs[3] = mk(1, 1, 1, 32'h8000_0100, 32'h8000_2100, 32'h0BAD_F00D, 8'hFF, 0, 32'h1111_2222,
                 1, 32'h8000_2100, 1, 8'hFF, 32'h0);
    vecs[4] = mk(1, 1, 0, 32'h8000_0004, 32'h8000_3000, 32'h0, 8'h00, 0, 32'hA000_0001,
                 1, 32'h8000_3000, 0, 8'h00, 32'hA000_0001);
    vecs[5] = mk(1, 1, 0, 32'h8000_0008, 32'h8000_3004, 32'h0, 8'h00, 0, 32'hA000_0002,
                 1, 32'h8000_3004, 0, 8'h00, 32'hA000_0002);
    vecs[6] = mk(1, 1, 0, 32'h8000_000C, 32'h8000_3008, 32'h0, 8'h00, 0, 32'hA000_0003,
                 1, 32'h8000_3008, 0, 8'h00, 32'hA000_0003);
    vecs[7] = mk(1, 1, 0, 32'h8000_0010, 32'h8000_300C, 32'h0, 8'h00, 0, 32'hA000_0004,
                 1, 32'h8000_300C, 0, 8'h00, 32'hA000_0004);
`endif

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("reset_release");

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    idle_inputs();
    @(posedge clk); #1;

    // Timeout: memory accepts but never answers.
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_4000;
    #2;
    chk("to.grant", bus.lsu_req_ready, 1'b1);
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #2;
    chk("to.mem_valid", bus.mem_req_valid, 1'b1);
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    n = 0;
    err_early = 1'b0;
    while (!bus.lsu_resp_valid && n < 400) begin
      if (bus.err_timeout) err_early = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("to.wait_cycles", n, 255);
    chk("to.err_early", err_early, 1'b0);
    chk("to.err", bus.err_timeout, 1'b1);
    chk("to.rdata", bus.lsu_rdata, 32'h0);
    chk("to.ifu_resp", bus.ifu_resp_valid, 1'b0);
    @(posedge clk); #1;
    chk("to.idle_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
    chk("to.idle_valid", bus.mem_req_valid, 1'b0);
    run_vec(mk(1, 0, 0, 32'h8000_0020, 32'h0, 32'h0, 8'h00, 0, 32'h0000_0093,
               0, 32'h8000_0020, 0, 8'h00, 32'h0000_0093), "after_to");
    chk("to.err_sticky", bus.err_timeout, 1'b1);
    idle_inputs();

    // Reset while waiting, then a stray response arrives in IDLE.
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_5000;
    #2;
    chk("rw.grant", bus.lsu_req_ready, 1'b1);
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk_reset_outputs($sformatf("rw%0d", i));
      @(posedge clk); #1;
    end
    bus.mem_resp_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/ysyx_23060201_mem_arb.md
YSYX_23060201_MEM_ARB -- requirements
Module: ysyx_23060201_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width of all channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of all channels.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for mem_resp_valid.
REQ-004 SHALL have clk  in  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ifu_req_valid  in  1; ifu_req_ready  out  1; ifu_addr  in  ADDR_WIDTH: fetch request, read only.
REQ-007 SHALL have ifu_resp_valid  out  1; ifu_rdata  out  DATA_WIDTH: fetch response.
REQ-008 SHALL have lsu_req_valid  in  1; lsu_req_ready  out  1; lsu_wen  in  1; lsu_addr  in  ADDR_WIDTH; lsu_wdata  in  DATA_WIDTH; lsu_wmask  in  8: load/store request.
REQ-009 SHALL have lsu_resp_valid  out  1; lsu_rdata  out  DATA_WIDTH: load data or store acknowledge.
REQ-010 SHALL have mem_req_valid  out  1; mem_req_ready  in  1; mem_wen  out  1; mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH; mem_wmask  out  8: shared memory port.
REQ-011 SHALL have mem_resp_valid  in  1; mem_rdata  in  DATA_WIDTH; err_timeout  out  1: memory response and sticky timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-013 IDLE: if any req_valid, SHALL select one winner, assert that requester's req_ready for exactly that cycle, latch its address/wdata/wmask/wen (IFU: wen=0, wmask=0), go to REQ.
REQ-014 A requester's transfer SHALL occur only on the cycle both its req_valid and req_ready are 1; req_ready SHALL be 0 in every state except IDLE.
REQ-015 REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready=1 go to WAIT; mem_req_valid SHALL stay 1 until accepted.
REQ-016 WAIT: on mem_resp_valid=1 latch mem_rdata, go to RESP; mem_resp_valid in any other state SHALL be ignored.
REQ-017 RESP: owner's resp_valid=1 for exactly one cycle with rdata = latched data (for stores rdata = 0), then IDLE; the other requester's resp_valid stays 0.
REQ-018 Earliest new grant SHALL be the cycle after RESP; minimum transaction latency request-accept to resp_valid = 3 cycles (accept, REQ with ready=1, WAIT with resp=1, RESP).
REQ-019 Timeout counter SHALL clear on entry to WAIT, increment each WAIT cycle; when it reaches TIMEOUT with no response, set err_timeout=1, deliver resp_valid with rdata=0 via RESP, return to IDLE.
REQ-020 err_timeout SHALL remain 1 until reset; counter width SHALL be clog2(TIMEOUT+1) and never wrap.
REQ-021 ifu_rdata/lsu_rdata SHALL be driven from the single latched data register; values outside the resp_valid cycle are don't-care but SHALL be 0 after reset.

Reset
REQ-022 On rst=1 at a clock edge: state=IDLE, all req_ready/resp_valid/mem_req_valid=0, mem_wen=0, mem_wmask=0, latched addr/data=0, counter=0, err_timeout=0, priority pointer=LSU-first.
REQ-023 Reset asserted mid-transaction SHALL abandon it silently: no resp_valid issued; a later stray mem_resp_valid in IDLE SHALL be ignored.

Configuration
REQ-024 Macro YSYX_23060201_MEM_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not granted last wins; pointer updates on each grant.
REQ-025 Macro undefined: fixed priority, LSU always wins simultaneous requests; IFU granted only when lsu_req_valid=0 in IDLE.

Verification
REQ-026 Single IFU read addr 0x80000000, mem_req_ready=1, resp next cycle rdata 0x00000413 -> ifu_resp_valid one cycle, ifu_rdata=0x00000413, 3-cycle latency, lsu_resp_valid never 1.
REQ-027 LSU store addr 0x80001000 wdata 0xDEADBEEF wmask 0x0F, mem_req_ready low 4 cycles -> mem_req_valid held with stable fields 5 cycles, lsu_resp_valid after response, lsu_rdata=0.
REQ-028 Both valid every cycle for 4 transactions -> RR_EN: grants LSU,IFU,LSU,IFU; undefined: LSU x4, IFU starved.
REQ-029 mem_resp_valid never returned, TIMEOUT=255 -> err_timeout=1 after 255 WAIT cycles, owner resp_valid with rdata=0, FSM back to IDLE, next request serviced normally.
REQ-030 rst pulsed in WAIT, then mem_resp_valid arrives in IDLE -> no resp_valid on either side, all outputs at reset values, err_timeout=0.
